// File: rtl/result_display_driver.sv
// Result-interface consumer: signed decimal conversion (sequential double-dabble)
// and 4-digit multiplexed common-anode seven-segment drive. Define HEX_MODE_EN for raw hex display.
module result_display_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [3:0] res_sum,
  input  logic       res_cout,
  input  logic       res_sub,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [6:0]       SEG_BLANK = 7'b1111111;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  function automatic logic [6:0] dec_glyph(input logic [3:0] v);
    case (v)
      4'd0:    dec_glyph = 7'b1000000;
      4'd1:    dec_glyph = 7'b1111001;
      4'd2:    dec_glyph = 7'b0100100;
      4'd3:    dec_glyph = 7'b0110000;
      4'd4:    dec_glyph = 7'b0011001;
      4'd5:    dec_glyph = 7'b0010010;
      4'd6:    dec_glyph = 7'b0000010;
      4'd7:    dec_glyph = 7'b1111000;
      4'd8:    dec_glyph = 7'b0000000;
      4'd9:    dec_glyph = 7'b0010000;
      default: dec_glyph = SEG_BLANK;
    endcase
  endfunction

  state_t     state;
  logic       ready_q;
  logic       cap;
  logic [6:0] dig0, dig1, dig2;

  assign cap       = res_valid && ready_q;
  assign res_ready = ready_q;
  assign dp        = 1'b1;

`ifdef HEX_MODE_EN
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'ha:    hex_glyph = 7'b0001000;
      4'hb:    hex_glyph = 7'b0000011;
      4'hc:    hex_glyph = 7'b1000110;
      4'hd:    hex_glyph = 7'b0100001;
      4'he:    hex_glyph = 7'b0000110;
      4'hf:    hex_glyph = 7'b0001110;
      default: hex_glyph = dec_glyph(v);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      dig0    <= SEG_BLANK;
      dig1    <= SEG_BLANK;
      dig2    <= SEG_BLANK;
    end else if (cap) begin
      state <= SHOW;
      dig0  <= hex_glyph(res_sum);
      dig1  <= dec_glyph({3'b000, res_cout});
      dig2  <= SEG_BLANK;
    end
  end
`else
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic       neg;
  logic [2:0] iter;
  logic [2:0] dd_tens;
  logic [3:0] dd_ones;
  logic [4:0] dd_bin;
  logic [3:0] ones_adj, fin_ones, fin_tens;
  logic [4:0] mag;

  // fin_* is the BCD state after the current iteration's add-3 and shift;
  // on the last CONV cycle it is the final result loaded into the digits.
  always_comb begin
    ones_adj = (dd_ones >= 4'd5) ? dd_ones + 4'd3 : dd_ones;
    fin_ones = {ones_adj[2:0], dd_bin[4]};
    fin_tens = {dd_tens, ones_adj[3]};
    if (!res_sub)
      mag = {res_cout, res_sum};
    else if (res_cout)
      mag = {1'b0, res_sum};
    else
      mag = 5'd16 - {1'b0, res_sum};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      dig0    <= SEG_BLANK;
      dig1    <= SEG_BLANK;
      dig2    <= SEG_BLANK;
      neg     <= 1'b0;
      iter    <= '0;
      dd_tens <= '0;
      dd_ones <= '0;
      dd_bin  <= '0;
    end else begin
      case (state)
        IDLE, SHOW: begin
          if (cap) begin
            state   <= CONV;
            ready_q <= 1'b0;
            neg     <= res_sub && !res_cout;
            iter    <= '0;
            dd_tens <= '0;
            dd_ones <= '0;
            dd_bin  <= mag;
          end
        end
        CONV: begin
          dd_tens <= fin_tens[2:0];
          dd_ones <= fin_ones;
          dd_bin  <= {dd_bin[3:0], 1'b0};
          iter    <= iter + 3'd1;
          if (iter == 3'd4) begin
            state   <= SHOW;
            ready_q <= 1'b1;
            dig0    <= dec_glyph(fin_ones);
            dig1    <= (fin_tens == 4'd0) ? SEG_BLANK : dec_glyph(fin_tens);
            dig2    <= neg ? SEG_DASH : SEG_BLANK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [6:0]       cur_seg;

  always_comb begin
    case (idx)
      2'd0:    cur_seg = dig0;
      2'd1:    cur_seg = dig1;
      2'd2:    cur_seg = dig2;
      default: cur_seg = SEG_BLANK;
    endcase
  end

  // On each wrap the digit at the current index is driven, then the index advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      an  <= '1;
      seg <= SEG_BLANK;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
      an  <= ~(4'b0001 << idx);
      seg <= cur_seg;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_result_display_driver.sv
// Directed self-checking bench for result_display_driver (small refresh divider).
module tb_result_display_driver;

  localparam int RDIV = 4;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_sum;
  logic       res_cout;
  logic       res_sub;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int vectors = 0;
  int miscompares = 0;

  result_display_driver #(.REFRESH_DIV(RDIV), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_sub(res_sub),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input string tag, input logic [3:0] s, input logic c,
                           input logic b, input int exp_low);
    int low;
    @(negedge clk);
    res_sum = s; res_cout = c; res_sub = b; res_valid = 1'b1;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      res_valid = 1'b0;
      if (res_ready) break;
      low++;
    end
    check({tag, "_ready_low"}, low, exp_low);
  endtask

  task automatic check_display(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp [4];
    logic [3:0] tgt;
    bit found;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    repeat (RDIV + 1) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      tgt = ~(4'b0001 << d);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (an == tgt) begin found = 1'b1; break; end
        @(negedge clk);
      end
      check($sformatf("%s_an%0d_seen", tag, d), found, 1);
      check($sformatf("%s_d%0d", tag, d), seg, exp[d]);
    end
  endtask

  task automatic first_anode(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_prewrap_an"}, an, 4'b1111);
    @(negedge clk);
    check({tag, "_first_an"}, an, 4'b1110);
    check({tag, "_first_seg"}, seg, B);
  endtask

  initial begin
    rst_n = 1'b0; res_valid = 1'b0; res_sum = '0; res_cout = 1'b0; res_sub = 1'b0;
    #12;
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, B);
    check("rst_dp", dp, 1'b1);
    check("rst_ready", res_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    first_anode("rel");

`ifdef HEX_MODE_EN
    send_word("hexE", 4'b1110, 1'b1, 1'b0, 0);
    check_display("hexE", 7'b0000110, 7'b1111001, B, B);
    send_word("hexA", 4'b1010, 1'b0, 1'b0, 0);
    check_display("hexA", 7'b0001000, 7'b1000000, B, B);
`else
    // 9+8 = 17
    send_word("add17", 4'b0001, 1'b1, 1'b0, 5);
    check_display("add17", 7'b1111000, 7'b1111001, B, B);
    // 3-7 = -4
    send_word("subm4", 4'b1100, 1'b0, 1'b1, 5);
    check_display("subm4", 7'b0011001, B, DS, B);
    // 9-4 = +5 (subtract with carry out)
    send_word("subp5", 4'b0101, 1'b1, 1'b1, 5);
    check_display("subp5", 7'b0010010, B, B, B);

    // Back-to-back: 15+15 = 30 then 7-2 = +5, valid held between them
    begin
      int falls;
      logic prev;
      falls = 0; prev = 1'b1;
      @(negedge clk);
      res_sum = 4'b1110; res_cout = 1'b1; res_sub = 1'b0; res_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (prev && !res_ready) begin
          falls++;
          if (falls == 1) begin
            res_sum = 4'b0101; res_cout = 1'b1; res_sub = 1'b1;
          end else begin
            res_valid = 1'b0;
          end
        end
        prev = res_ready;
        if (falls >= 2 && res_ready) break;
      end
      res_valid = 1'b0;
      check("b2b_captures", falls, 2);
      repeat (8) @(negedge clk);
      check("b2b_ready_idle", res_ready, 1'b1);
      check_display("b2b", 7'b0010010, B, B, B);
    end

    // 15+15 = 30 alone, to exercise tens=3 and ones=0
    send_word("add30", 4'b1110, 1'b1, 1'b0, 5);
    check_display("add30", 7'b1000000, 7'b0110000, B, B);

    // Reset during third CONV cycle of a 3-0 conversion
    @(negedge clk);
    res_sum = 4'b0011; res_cout = 1'b1; res_sub = 1'b1; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    check("mid_conv_ready", res_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_an", an, 4'b1111);
    check("abort_seg", seg, B);
    check("abort_ready", res_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    first_anode("rel2");
    check_display("post_rst", B, B, B, B);
    check("post_rst_ready", res_ready, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
